// File: rtl/ram_sched_pkg.sv
// Shared constants and types for the ram_4w4r write-port scheduler.
package ram_sched_pkg;

   localparam int RAM_WR_PORTS = 4;
   localparam int SCHED_ADDR_W = 7;
   localparam int SCHED_DATA_W = 64;
   // Up to NUM_REQ-1 (<= 15) requests can be deferred in one cycle.
   localparam int DEFER_W      = 5;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic                    val;
      logic [SCHED_ADDR_W-1:0] addr;
      logic [SCHED_DATA_W-1:0] data;
   } wr_port_t;

endpackage

// File: rtl/ram_wr_sched_pick.sv
// Round-robin pick of up to four address-distinct write requests per cycle.
module ram_wr_sched_pick
   import ram_sched_pkg::*;
#(
   parameter int  NUM_REQ        = 8,
   parameter int  RAM_ADDR_WIDTH = 7,
   localparam int PTR_W          = ptr_width(NUM_REQ)
) (
   input  logic [PTR_W-1:0]                      rr_ptr,
   input  logic [NUM_REQ-1:0]                    req_val,
   input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0]     req_addr,
   output logic [NUM_REQ-1:0]                    req_rdy,
   output logic [RAM_WR_PORTS-1:0][PTR_W-1:0]    port_idx,
   output logic [RAM_WR_PORTS-1:0]               port_val,
   output logic [DEFER_W-1:0]                    defer_cnt,
   output logic [PTR_W-1:0]                      rr_next
);

   logic [RAM_WR_PORTS-1:0][RAM_ADDR_WIDTH-1:0] gnt_addr;
   logic [2:0]                                  gnt_n;
   logic [PTR_W-1:0]                            idx;
   logic [RAM_ADDR_WIDTH-1:0]                   addr;
   logic                                        clash;

   always_comb begin
      req_rdy   = '0;
      port_idx  = '0;
      port_val  = '0;
      defer_cnt = '0;
      rr_next   = rr_ptr;
      gnt_addr  = '0;
      gnt_n     = '0;
      idx       = '0;
      addr      = '0;
      clash     = 1'b0;
      for (int s = 0; s < NUM_REQ; s++) begin
         idx   = PTR_W'((int'(rr_ptr) + s) % NUM_REQ);
         addr  = req_addr[idx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
         clash = 1'b0;
         for (int g = 0; g < RAM_WR_PORTS; g++) begin
            if (g < int'(gnt_n) && gnt_addr[g] == addr) clash = 1'b1;
         end
         // Once all four ports are taken, a clash no longer counts as a deferral.
         if (req_val[idx] && gnt_n < 3'(RAM_WR_PORTS)) begin
            if (clash) begin
               defer_cnt = defer_cnt + DEFER_W'(1);
            end else begin
               req_rdy[idx]            = 1'b1;
               port_idx[gnt_n[1:0]]    = idx;
               port_val[gnt_n[1:0]]    = 1'b1;
               gnt_addr[gnt_n[1:0]]    = addr;
               gnt_n                   = gnt_n + 3'd1;
               rr_next                 = PTR_W'((int'(idx) + 1) % NUM_REQ);
            end
         end
      end
   end

endmodule

// File: rtl/ram_4w_wr_sched.sv
// Write-port scheduler for ram_4w4r: grants up to four same-cycle writes with
// distinct addresses and presents them on w0..w3 through one register stage.
module ram_4w_wr_sched
   import ram_sched_pkg::*;
#(
   parameter int NUM_REQ        = 8,
   parameter int RAM_DEPTH      = 128,
   parameter int RAM_ADDR_WIDTH = SCHED_ADDR_W,
   parameter int RAM_DATA_WIDTH = SCHED_DATA_W,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_val,
   input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*RAM_DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]                req_rdy,
   output logic                              w0_val,
   output logic                              w1_val,
   output logic                              w2_val,
   output logic                              w3_val,
   output logic [RAM_ADDR_WIDTH-1:0]         w0_addr,
   output logic [RAM_ADDR_WIDTH-1:0]         w1_addr,
   output logic [RAM_ADDR_WIDTH-1:0]         w2_addr,
   output logic [RAM_ADDR_WIDTH-1:0]         w3_addr,
   output logic [RAM_DATA_WIDTH-1:0]         w0_data,
   output logic [RAM_DATA_WIDTH-1:0]         w1_data,
   output logic [RAM_DATA_WIDTH-1:0]         w2_data,
   output logic [RAM_DATA_WIDTH-1:0]         w3_data,
   output logic [CNT_WIDTH-1:0]              conflict_cnt
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   if (RAM_DEPTH > (1 << RAM_ADDR_WIDTH)) begin : g_depth_chk
      $error("RAM_DEPTH does not fit in RAM_ADDR_WIDTH");
   end

   logic [PTR_W-1:0]                   rr_q, rr_d, rr_next;
   logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
   wr_port_t [RAM_WR_PORTS-1:0]        port_q, port_d;
   logic [NUM_REQ-1:0]                 pick_rdy;
   logic [RAM_WR_PORTS-1:0][PTR_W-1:0] port_idx;
   logic [RAM_WR_PORTS-1:0]            port_val;
   logic [DEFER_W-1:0]                 defer_cnt;

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [DEFER_W-1:0]   b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + {{(CNT_WIDTH+1-DEFER_W){1'b0}}, b};
      return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
   endfunction

   ram_wr_sched_pick #(
      .NUM_REQ        (NUM_REQ),
      .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
   ) u_pick (
      .rr_ptr    (rr_q),
      .req_val   (req_val),
      .req_addr  (req_addr),
      .req_rdy   (pick_rdy),
      .port_idx  (port_idx),
      .port_val  (port_val),
      .defer_cnt (defer_cnt),
      .rr_next   (rr_next)
   );

   // Grants are suppressed during reset so nothing is lost by a requester.
   assign req_rdy = rst_n ? pick_rdy : '0;

   always_comb begin
      port_d = '0;
      for (int k = 0; k < RAM_WR_PORTS; k++) begin
         if (port_val[k]) begin
            port_d[k].val  = 1'b1;
            port_d[k].addr = req_addr[port_idx[k]*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            port_d[k].data = req_data[port_idx[k]*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
         end
      end
      rr_d  = rr_next;
      cnt_d = sat_add(cnt_q, defer_cnt);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q   <= '0;
         cnt_q  <= '0;
         port_q <= '0;
      end else begin
         rr_q   <= rr_d;
         cnt_q  <= cnt_d;
         port_q <= port_d;
      end
   end

   assign w0_val  = port_q[0].val;
   assign w1_val  = port_q[1].val;
   assign w2_val  = port_q[2].val;
   assign w3_val  = port_q[3].val;
   assign w0_addr = port_q[0].addr;
   assign w1_addr = port_q[1].addr;
   assign w2_addr = port_q[2].addr;
   assign w3_addr = port_q[3].addr;
   assign w0_data = port_q[0].data;
   assign w1_data = port_q[1].data;
   assign w2_data = port_q[2].data;
   assign w3_data = port_q[3].data;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_4w_wr_sched.sv
// Bench for ram_4w_wr_sched: directed scenarios plus randomized traffic
// against a queue-based scan model and a small behavioural RAM.
module tb_ram_4w_wr_sched;

   localparam int NR = 8;
   localparam int AW = 7;
   localparam int DW = 64;
   localparam int CW = 16;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_val;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_rdy;
   logic             w0_val, w1_val, w2_val, w3_val;
   logic [AW-1:0]    w0_addr, w1_addr, w2_addr, w3_addr;
   logic [DW-1:0]    w0_data, w1_data, w2_data, w3_data;
   logic [CW-1:0]    conflict_cnt;

   logic             w_val  [4];
   logic [AW-1:0]    w_addr [4];
   logic [DW-1:0]    w_data [4];
   assign w_val[0] = w0_val;   assign w_addr[0] = w0_addr;   assign w_data[0] = w0_data;
   assign w_val[1] = w1_val;   assign w_addr[1] = w1_addr;   assign w_data[1] = w1_data;
   assign w_val[2] = w2_val;   assign w_addr[2] = w2_addr;   assign w_data[2] = w2_data;
   assign w_val[3] = w3_val;   assign w_addr[3] = w3_addr;   assign w_data[3] = w3_data;

   always #5 clk = ~clk;

   ram_4w_wr_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_val      (req_val),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_rdy      (req_rdy),
      .w0_val       (w0_val),
      .w1_val       (w1_val),
      .w2_val       (w2_val),
      .w3_val       (w3_val),
      .w0_addr      (w0_addr),
      .w1_addr      (w1_addr),
      .w2_addr      (w2_addr),
      .w3_addr      (w3_addr),
      .w0_data      (w0_data),
      .w1_data      (w1_data),
      .w2_data      (w2_data),
      .w3_data      (w3_data),
      .conflict_cnt (conflict_cnt)
   );

   // Behavioural stand-in for ram_4w4r's write side.
   logic [DW-1:0] tbmem [0:127];
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) if (w_val[k] === 1'b1) tbmem[w_addr[k]] <= w_data[k];
   end

   int            n_checks = 0;
   int            n_pass   = 0;
   int            m_rr     = 0;
   int            m_cnt    = 0;
   logic [NR-1:0] e_rdy;
   int            e_defer;
   int            e_rr_next;
   int            e_gidx  [$];
   logic [AW-1:0] e_gaddr [$];
   logic [DW-1:0] e_gdata [$];
   logic          exp_wval  [4];
   logic [AW-1:0] exp_waddr [4];
   logic [DW-1:0] exp_wdata [4];

   task automatic set_req(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_val[j]          = 1'b1;
      req_addr[j*AW +: AW] = a;
      req_data[j*DW +: DW] = d;
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Scan the requesters from the pointer, granting distinct addresses up to four.
   task automatic model_eval();
      int            j;
      bit            clash;
      logic [AW-1:0] a;
      e_rdy = '0; e_defer = 0; e_rr_next = m_rr;
      e_gidx.delete(); e_gaddr.delete(); e_gdata.delete();
      if (rst_n !== 1'b1) return;
      for (int s = 0; s < NR; s++) begin
         j = (m_rr + s) % NR;
         a = req_addr[j*AW +: AW];
         if (!req_val[j] || e_gidx.size() == 4) continue;
         clash = 0;
         foreach (e_gaddr[g]) if (e_gaddr[g] == a) clash = 1;
         if (clash) begin
            e_defer++;
            continue;
         end
         e_gidx.push_back(j);
         e_gaddr.push_back(a);
         e_gdata.push_back(req_data[j*DW +: DW]);
         e_rdy[j]  = 1'b1;
         e_rr_next = (j + 1) % NR;
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      if (rst_n !== 1'b1) begin
         m_rr = 0; m_cnt = 0;
         for (int k = 0; k < 4; k++) begin
            exp_wval[k] = 1'b0; exp_waddr[k] = '0; exp_wdata[k] = '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            exp_wval[k] = (k < e_gidx.size());
            if (exp_wval[k]) begin
               exp_waddr[k] = e_gaddr[k]; exp_wdata[k] = e_gdata[k];
            end
         end
         m_rr  = e_rr_next;
         m_cnt = (m_cnt + e_defer > CNT_MAX) ? CNT_MAX : m_cnt + e_defer;
      end
      #1;
   endtask

   task automatic drop_granted();
      foreach (e_gidx[i]) req_val[e_gidx[i]] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_val = '1;
      for (int j = 0; j < NR; j++) set_req(j, AW'(j), rnd64());
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (req_rdy !== 8'h00) $display("FAIL reset_rdy: got %h want 00", req_rdy);
         else n_pass++;
         tick();
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (w_val[k] !== 1'b0 || w_addr[k] !== '0 || w_data[k] !== '0)
               $display("FAIL reset_w%0d: got val=%b addr=%h data=%h want all 0", k, w_val[k], w_addr[k], w_data[k]);
            else n_pass++;
         end
         n_checks++;
         if (conflict_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", conflict_cnt);
         else n_pass++;
      end
      rst_n = 1'b1; #1;
      n_checks++;
      if (req_rdy !== 8'h0F) $display("FAIL reset_first_rdy: got %h want 0f", req_rdy);
      else n_pass++;
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (w_val[k] !== 1'b1 || w_addr[k] !== AW'(k) || w_data[k] !== req_data[k*DW +: DW])
            $display("FAIL reset_first_w%0d: got val=%b addr=%h want val=1 addr=%h", k, w_val[k], w_addr[k], k);
         else n_pass++;
      end
      drop_granted(); #1;
      n_checks++;
      if (req_rdy !== 8'hF0) $display("FAIL reset_second_rdy: got %h want f0", req_rdy);
      else n_pass++;
      tick(); drop_granted();
   endtask

   task automatic test_three_distinct();
      logic [DW-1:0] d [3];
      for (int j = 0; j < 3; j++) begin
         d[j] = rnd64(); set_req(j, AW'(8'h10 + j), d[j]);
      end
      #1;
      n_checks++;
      if (req_rdy !== 8'h07) $display("FAIL three_rdy: got %h want 07", req_rdy);
      else n_pass++;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (w_val[k] !== 1'b1 || w_addr[k] !== AW'(8'h10 + k) || w_data[k] !== d[k])
            $display("FAIL three_w%0d: got val=%b addr=%h data=%h want 1 %h %h", k, w_val[k], w_addr[k], w_data[k], 8'h10 + k, d[k]);
         else n_pass++;
      end
      n_checks++;
      if (w3_val !== 1'b0) $display("FAIL three_w3_idle: got %b want 0", w3_val);
      else n_pass++;
      drop_granted();
      // Pointer now 3; a lone request from 7 must win and returns the pointer to 0.
      set_req(7, 7'h55, rnd64()); #1;
      n_checks++;
      if (req_rdy !== 8'h80) $display("FAIL three_ptr_rdy: got %h want 80", req_rdy);
      else n_pass++;
      tick(); drop_granted();
   endtask

   task automatic test_full_load();
      for (int j = 0; j < NR; j++) set_req(j, AW'(8'h30 + j), rnd64());
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++;
         if (req_rdy !== (c == 0 ? 8'h0F : 8'hF0))
            $display("FAIL full_rdy%0d: got %h want %h", c, req_rdy, (c == 0 ? 8'h0F : 8'hF0));
         else n_pass++;
         tick();
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (w_val[k] !== 1'b1 || w_addr[k] !== AW'(8'h30 + 4*c + k) || w_data[k] !== req_data[(4*c+k)*DW +: DW])
               $display("FAIL full_w%0d_c%0d: got val=%b addr=%h want 1 %h", k, c, w_val[k], w_addr[k], 8'h30 + 4*c + k);
            else n_pass++;
         end
         drop_granted();
      end
      n_checks++;
      if (conflict_cnt !== 16'd0) $display("FAIL full_cnt: got %0d want 0", conflict_cnt);
      else n_pass++;
   endtask

   task automatic test_conflict();
      logic [DW-1:0] da, db;
      da = rnd64(); db = ~da;
      set_req(2, 7'h20, da); set_req(5, 7'h20, db); #1;
      n_checks++;
      if (req_rdy !== 8'h04) $display("FAIL conf_rdy1: got %h want 04", req_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (conflict_cnt !== 16'd1) $display("FAIL conf_cnt: got %0d want 1", conflict_cnt);
      else n_pass++;
      n_checks++;
      if (w0_val !== 1'b1 || w0_data !== da || w1_val !== 1'b0)
         $display("FAIL conf_first: got w0=%b/%h w1=%b want 1/%h 0", w0_val, w0_data, w1_val, da);
      else n_pass++;
      drop_granted(); #1;
      n_checks++;
      if (req_rdy !== 8'h20) $display("FAIL conf_rdy2: got %h want 20", req_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (w0_val !== 1'b1 || w0_addr !== 7'h20 || w0_data !== db)
         $display("FAIL conf_second: got w0=%b/%h/%h want 1/20/%h", w0_val, w0_addr, w0_data, db);
      else n_pass++;
      drop_granted();
      tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (w_val[k] !== 1'b0) $display("FAIL idle_w%0d: got %b want 0", k, w_val[k]);
         else n_pass++;
      end
      n_checks++;
      if (tbmem[7'h20] !== db) $display("FAIL conf_ram: got %h want %h", tbmem[7'h20], db);
      else n_pass++;
   endtask

   task automatic test_wrap();
      set_req(1, 7'h41, rnd64()); set_req(6, 7'h46, rnd64()); set_req(7, 7'h47, rnd64()); #1;
      n_checks++;
      if (req_rdy !== 8'hC2) $display("FAIL wrap_rdy: got %h want c2", req_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if (w0_addr !== 7'h46 || w1_addr !== 7'h47 || w2_addr !== 7'h41 || {w0_val, w1_val, w2_val, w3_val} !== 4'b1110)
         $display("FAIL wrap_ports: got %h %h %h val=%b%b%b%b want 46 47 41 1110",
                  w0_addr, w1_addr, w2_addr, w0_val, w1_val, w2_val, w3_val);
      else n_pass++;
      drop_granted();
   endtask

   task automatic test_reset_midop();
      for (int j = 0; j < NR; j++) set_req(j, AW'(8'h60 + j), rnd64());
      #1;
      n_checks++;
      if (req_rdy !== 8'h3C) $display("FAIL mid_rdy: got %h want 3c", req_rdy);
      else n_pass++;
      tick(); drop_granted();
      n_checks++;
      if ({w0_val, w1_val, w2_val, w3_val} !== 4'b1111 || w0_addr !== 7'h62)
         $display("FAIL mid_pre: got val=%b%b%b%b w0=%h want 1111 62", w0_val, w1_val, w2_val, w3_val, w0_addr);
      else n_pass++;
      rst_n = 1'b0; #1;
      n_checks++;
      if (req_rdy !== 8'h00) $display("FAIL mid_rdy_rst: got %h want 00", req_rdy);
      else n_pass++;
      tick();
      n_checks++;
      if ({w0_val, w1_val, w2_val, w3_val} !== 4'b0000 || conflict_cnt !== 16'd0)
         $display("FAIL mid_after: got val=%b%b%b%b cnt=%0d want 0000 0", w0_val, w1_val, w2_val, w3_val, conflict_cnt);
      else n_pass++;
      rst_n = 1'b1; req_val = '0;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int j = 0; j < NR; j++)
            if (!req_val[j] && $urandom_range(1, 0) == 1) set_req(j, AW'($urandom_range(7, 0)), rnd64());
         if (c % 37 == 0) req_val = '0;
         #1;
         model_eval();
         n_checks++;
         if (req_rdy !== e_rdy) $display("FAIL rand_rdy c%0d: got %h want %h", c, req_rdy, e_rdy);
         else n_pass++;
         tick();
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (w_val[k] !== exp_wval[k] || (exp_wval[k] && (w_addr[k] !== exp_waddr[k] || w_data[k] !== exp_wdata[k])))
               $display("FAIL rand_w%0d c%0d: got %b/%h/%h want %b/%h/%h", k, c, w_val[k], w_addr[k], w_data[k],
                        exp_wval[k], exp_waddr[k], exp_wdata[k]);
            else n_pass++;
         end
         n_checks++;
         if (conflict_cnt !== CW'(m_cnt)) $display("FAIL rand_cnt c%0d: got %0d want %0d", c, conflict_cnt, m_cnt);
         else n_pass++;
         drop_granted();
      end
      req_val = '0;
      tick();
   endtask

   task automatic test_saturation();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      for (int j = 0; j < NR; j++) set_req(j, 7'h7F, rnd64());
      // Every cycle grants one and defers seven: 9362 cycles reach 65534.
      for (int c = 0; c < 9362; c++) begin
         tick();
         foreach (e_gidx[i]) req_data[e_gidx[i]*DW +: DW] = rnd64();
      end
      n_checks++;
      if (conflict_cnt !== 16'd65534 || conflict_cnt !== CW'(m_cnt))
         $display("FAIL sat_pre: got %0d want 65534", conflict_cnt);
      else n_pass++;
      tick();
      n_checks++;
      if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_hit: got %h want ffff", conflict_cnt);
      else n_pass++;
      for (int c = 0; c < 5; c++) tick();
      n_checks++;
      if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", conflict_cnt);
      else n_pass++;
      req_val = '0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; req_val = '0; req_addr = '0; req_data = '0;
      for (int k = 0; k < 4; k++) begin
         exp_wval[k] = 1'b0; exp_waddr[k] = '0; exp_wdata[k] = '0;
      end
      test_reset();
      test_three_distinct();
      test_full_load();
      test_conflict();
      test_wrap();
      test_reset_midop();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_4w_wr_sched.md
Name: ram_4w_wr_sched

Overview:
Write-port scheduler in front of ram_4w4r. It accepts single-beat write requests from NUM_REQ independent requesters over valid/ready. Each cycle it grants up to 4 requests in round-robin order, and never grants two writes to the same address in one cycle, because the RAM gives no ordering for same-address writes. Granted writes drive the RAM's w0..w3 ports through one output register stage.

Parameters:
NUM_REQ, 8, number of write requesters (2..16)
RAM_DEPTH, 128, RAM entries
RAM_ADDR_WIDTH, 7, address width
RAM_DATA_WIDTH, 64, data width
CNT_WIDTH, 16, width of conflict counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req_val  input  NUM_REQ  per-requester write valid
req_addr  input  NUM_REQ*RAM_ADDR_WIDTH  packed addresses, requester i at slice i
req_data  input  NUM_REQ*RAM_DATA_WIDTH  packed data, requester i at slice i
req_rdy  output  NUM_REQ  per-requester grant (combinational)
w0_val/w1_val/w2_val/w3_val  output  1 each  RAM write valid (registered)
w0_addr..w3_addr  output  RAM_ADDR_WIDTH each  RAM write address (registered)
w0_data..w3_data  output  RAM_DATA_WIDTH each  RAM write data (registered)
conflict_cnt  output  CNT_WIDTH  count of same-address deferrals, saturating

Behaviour:
- Clocking and reset: clk, with rst_n synchronous and active-low.
- Handshake: a transfer occurs on a cycle with req_val[i] & req_rdy[i].
  - Once req_val[i] is asserted, requester i holds it, with addr and data stable, until the transfer.
  - req_rdy[i] never asserts without req_val[i].
- Pick order: scan requesters starting at rr_ptr: rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ, NUM_REQ positions in total.
- Grant rule: requester j is granted iff all of the following hold:
  - req_val[j] is set;
  - fewer than 4 grants have been made earlier in the scan;
  - req_addr[j] differs from the address of every earlier grant in the scan.
- Deferral: a valid request blocked only by the address rule is deferred and counted.
  - conflict_cnt increments by the number of such requests that cycle.
  - conflict_cnt saturates at all-ones.
  - Requests blocked only by the 4-grant limit are not counted.
- Port mapping: the k-th grant in scan order (k=0..3) drives port wk. Ports with no grant are driven invalid that cycle.
- Output latency: granted val/addr/data appear on wk_* at the next posedge, one cycle after the handshake. Each wk_val is a 1-cycle pulse per grant.
- Same-address ordering: the deferred writer always reaches the RAM at least one cycle after the granted writer, so the deferred writer's data is the final value. Cross-cycle order is preserved by the single register stage.
- rr_ptr update:
  - if any grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ;
  - otherwise rr_ptr holds.
- Reset:
  - rr_ptr = 0, all wk_val = 0, wk_addr = 0, wk_data = 0, conflict_cnt = 0;
  - req_rdy forced to 0 while rst_n = 0, regardless of req_val.
- Reset mid-operation: writes registered but not yet presented are dropped. wk_val is 0 on the first cycle after the reset edge.
- Degenerate cases:
  - all req_val = 0 gives no grants, all wk_val = 0 next cycle, rr_ptr holds;
  - NUM_REQ <= 4 with distinct addresses gives every valid requester its grant in the same cycle.

Decomposition:
- Shared package ram_sched_pkg holds:
  - constant RAM_WR_PORTS = 4;
  - a clog2-based pointer width function for NUM_REQ;
  - typedef of the per-port write bundle (val, addr, data).
- One sub-module, ram_wr_sched_pick:
  - purely combinational;
  - inputs: rr_ptr, req_val, req_addr;
  - outputs: req_rdy, per-port requester index and valid, deferral count, next rr_ptr.
- Top level holds the output registers, rr_ptr, conflict_cnt and the data muxing.

Test Plan:
1. Reset hold: rst_n=0 for 3 cycles with req_val=8'hFF -> req_rdy=0 and all wk_val=0 throughout; after release, rr_ptr=0, so requesters 0-3 are granted first.
2. Three distinct requests: req 0,1,2 at addr 0x10/0x11/0x12, rr_ptr=0 -> req_rdy=8'h07 that cycle; next cycle w0=0x10, w1=0x11, w2=0x12, w3_val=0; rr_ptr becomes 3.
3. Full load: all 8 valid at distinct addresses, rr_ptr=0 -> cycle 1 grants 0-3 (req_rdy=8'h0F), rr_ptr=4; cycle 2 grants 4-7 (8'hF0), rr_ptr=0; conflict_cnt stays 0.
4. Same-address conflict: req 2 and req 5 both at addr 0x20 (data A, B), rr_ptr=0:
   - cycle 1: req_rdy=8'h04, conflict_cnt=1, rr_ptr=3;
   - cycle 2: req5 granted on w0;
   - RAM read of 0x20 afterwards returns B.
5. Wrap-around: rr_ptr=6, req 1, 6, 7 valid -> w0=req6, w1=req7, w2=req1; rr_ptr becomes 2.
6. Reset mid-op and saturation:
   - rst_n=0 on the cycle after a 4-grant cycle -> all wk_val=0 after the edge, conflict_cnt=0;
   - separately, force 0xFFFF deferrals -> conflict_cnt holds at 0xFFFF.
